// File: rtl/sr_latch_bank.sv
// sr_latch_bank
//
// Clocked, debounced replacement for a bank of gate-level SR latches.
// Each of WIDTH channels takes an asynchronous active-low set/reset pair,
// synchronises it through two flops, accepts it only after it has been
// stable for DEBOUNCE synchronised samples, and then applies it to a
// registered latch bit. The simultaneous set+reset case is resolved by
// PRIORITY (0 hold, 1 set wins, 2 reset wins) and is reported on a sticky
// per-channel error flag.
//
// Ports
//   clk           single clock, all state updates on the rising edge
//   rst           synchronous reset, active-high, overrides every input
//   sbar[W]       active-low set requests, asynchronous to clk
//   rbar[W]       active-low reset requests, asynchronous to clk
//   en            1: accepted commands may update q; 0: q frozen
//   err_clr       clears every both_err bit (a same-cycle set wins)
//   q[W]          registered latch state
//   qbar[W]       combinational complement of q
//   both_err[W]   sticky: an accepted command had set and reset both active
//   change_pulse[W] high for the one cycle after q[i] took a new value
//
// Channels are fully independent; no state is shared between bits.

module sr_latch_bank #(
    parameter int               WIDTH    = 4,
    parameter int               DEBOUNCE = 3,
    parameter int               PRIORITY = 0,
    parameter logic [WIDTH-1:0] RESET_Q  = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sbar,
    input  logic [WIDTH-1:0] rbar,
    input  logic             en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] both_err,
    output logic [WIDTH-1:0] change_pulse
);

    // Configuration checks, evaluated at elaboration.
    if (PRIORITY < 0 || PRIORITY > 2) begin : g_bad_priority
        $error("sr_latch_bank: PRIORITY must be 0, 1 or 2");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sr_latch_bank: WIDTH must be at least 1");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("sr_latch_bank: DEBOUNCE must be at least 1");
    end

    localparam int             CW      = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    // Two-flop synchronisers, kept in the active-low sense so that the
    // reset value (all ones) means "no request".
    logic [WIDTH-1:0] sbar_meta, sbar_sync;
    logic [WIDTH-1:0] rbar_meta, rbar_sync;

    // Debounce state: last synchronised pair and how long it has held.
    logic [WIDTH-1:0]         last_sbar, last_rbar;
    logic [WIDTH-1:0][CW-1:0] cnt;

    logic [WIDTH-1:0] q_reg, err_reg, change_reg;

    // Accepted command (level) and next-state values.
    logic [WIDTH-1:0] stable, acc_s, acc_r;
    logic [WIDTH-1:0] q_next, err_next;

    always_comb begin
        stable = '0;
        acc_s  = '0;
        acc_r  = '0;
        q_next = q_reg;
        for (int i = 0; i < WIDTH; i++) begin
            // A pair counts as accepted once it has survived DEBOUNCE
            // consecutive samples; it then re-applies every cycle.
            stable[i] = (cnt[i] == CNT_MAX);
            acc_s[i]  = stable[i] & ~last_sbar[i];
            acc_r[i]  = stable[i] & ~last_rbar[i];
            if (en) begin
                case ({acc_s[i], acc_r[i]})
                    2'b10:   q_next[i] = 1'b1;
                    2'b01:   q_next[i] = 1'b0;
                    2'b11: begin
                        if (PRIORITY == 1)      q_next[i] = 1'b1;
                        else if (PRIORITY == 2) q_next[i] = 1'b0;
                        else                    q_next[i] = q_reg[i];
                    end
                    default: q_next[i] = q_reg[i];
                endcase
            end
        end
        // Setting beats clearing when both happen in the same cycle.
        err_next = (err_reg & ~{WIDTH{err_clr}}) | (acc_s & acc_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sbar_meta  <= '1;
            sbar_sync  <= '1;
            rbar_meta  <= '1;
            rbar_sync  <= '1;
            last_sbar  <= '1;
            last_rbar  <= '1;
            cnt        <= '0;
            q_reg      <= RESET_Q;
            err_reg    <= '0;
            change_reg <= '0;
        end else begin
            sbar_meta <= sbar;
            sbar_sync <= sbar_meta;
            rbar_meta <= rbar;
            rbar_sync <= rbar_meta;
            for (int i = 0; i < WIDTH; i++) begin
                if (sbar_sync[i] != last_sbar[i] || rbar_sync[i] != last_rbar[i]) begin
                    last_sbar[i] <= sbar_sync[i];
                    last_rbar[i] <= rbar_sync[i];
                    cnt[i]       <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
            q_reg      <= q_next;
            err_reg    <= err_next;
            // Only a real value change pulses; rewriting the same value does not.
            change_reg <= q_next ^ q_reg;
        end
    end

    assign q            = q_reg;
    assign qbar         = ~q_reg;
    assign both_err     = err_reg;
    assign change_pulse = change_reg;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Testbench for sr_latch_bank. Three instances share one stimulus stream:
// PRIORITY 0/1/2, the last one with RESET_Q = 4'b1010. A reference model
// works from the input history (acceptance = the last DEBOUNCE synchronised
// samples agree), pushes expected outputs per edge into exp_q, and a
// monitor on the falling edge pops and compares.

module tb_sr_latch_bank;

    localparam int W  = 4;
    localparam int D  = 3;
    localparam int N  = 3;
    localparam int EW = N * 3 * W;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         err_clr;
    logic [W-1:0] sbar;
    logic [W-1:0] rbar;

    logic [W-1:0] q_a [N];
    logic [W-1:0] qb_a[N];
    logic [W-1:0] e_a [N];
    logic [W-1:0] c_a [N];

    int n_checks = 0;
    int n_err    = 0;

    logic [EW-1:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sr_latch_bank #(.WIDTH(W), .DEBOUNCE(D), .PRIORITY(0), .RESET_Q(4'b0000)) u_p0 (
        .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar), .en(en), .err_clr(err_clr),
        .q(q_a[0]), .qbar(qb_a[0]), .both_err(e_a[0]), .change_pulse(c_a[0]));

    sr_latch_bank #(.WIDTH(W), .DEBOUNCE(D), .PRIORITY(1), .RESET_Q(4'b0000)) u_p1 (
        .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar), .en(en), .err_clr(err_clr),
        .q(q_a[1]), .qbar(qb_a[1]), .both_err(e_a[1]), .change_pulse(c_a[1]));

    sr_latch_bank #(.WIDTH(W), .DEBOUNCE(D), .PRIORITY(2), .RESET_Q(4'b1010)) u_p2 (
        .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar), .en(en), .err_clr(err_clr),
        .q(q_a[2]), .qbar(qb_a[2]), .both_err(e_a[2]), .change_pulse(c_a[2]));

    // ---------------- reference model ----------------
    int           pri_m[N] = '{0, 1, 2};
    logic [W-1:0] rq_m [N] = '{4'b0000, 4'b0000, 4'b1010};
    logic [W-1:0] mq  [N];
    logic [W-1:0] merr[N];
    logic [W-1:0] mcp [N];

    // Each entry is {sbar, rbar}. raw_q delays by the two synchroniser
    // stages; v_hist holds the synchronised samples seen since reset.
    logic [2*W-1:0] raw_q[$];
    logic [2*W-1:0] v_hist[$];

    function automatic logic accepted(input int i);
        if (v_hist.size() < D) return 1'b0;
        for (int j = 0; j < D; j++) begin
            if (v_hist[j][W+i] != v_hist[0][W+i] || v_hist[j][i] != v_hist[0][i])
                return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        logic [W-1:0]  as_v, ar_v, old_q;
        logic [EW-1:0] e;
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                mq[k]   = rq_m[k];
                merr[k] = '0;
                mcp[k]  = '0;
            end
            raw_q  = '{{2*W{1'b1}}, {2*W{1'b1}}};
            v_hist = '{{2*W{1'b1}}};
        end else begin
            as_v = '0;
            ar_v = '0;
            for (int i = 0; i < W; i++) begin
                if (accepted(i)) begin
                    as_v[i] = ~v_hist[D-1][W+i];
                    ar_v[i] = ~v_hist[D-1][i];
                end
            end
            for (int k = 0; k < N; k++) begin
                old_q = mq[k];
                if (en) begin
                    for (int i = 0; i < W; i++) begin
                        if (as_v[i] && !ar_v[i])      mq[k][i] = 1'b1;
                        else if (!as_v[i] && ar_v[i]) mq[k][i] = 1'b0;
                        else if (as_v[i] && ar_v[i]) begin
                            if (pri_m[k] == 1)      mq[k][i] = 1'b1;
                            else if (pri_m[k] == 2) mq[k][i] = 1'b0;
                        end
                    end
                end
                merr[k] = (merr[k] & ~{W{err_clr}}) | (as_v & ar_v);
                mcp[k]  = old_q ^ mq[k];
            end
            v_hist.push_back(raw_q.pop_front());
            raw_q.push_back({sbar, rbar});
            if (v_hist.size() > D) void'(v_hist.pop_front());
        end
        for (int k = 0; k < N; k++) e[k*3*W +: 3*W] = {mq[k], merr[k], mcp[k]};
        exp_q.push_back(e);
    end

    // ---------------- scoreboard / monitor ----------------
    task automatic check(input string name, input int k, input logic [W-1:0] act,
                         input logic [W-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %b expected %b", name, k, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [W-1:0]  eq, ee, ec;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
                {eq, ee, ec} = e[k*3*W +: 3*W];
                check("q", k, q_a[k], eq);
                check("qbar", k, qb_a[k], ~eq);
                check("both_err", k, e_a[k], ee);
                check("change_pulse", k, c_a[k], ec);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; err_clr = 1'b0; sbar = '1; rbar = '1;
        cyc(2);
        rst = 1'b0;
        cyc(20);                                   // idle after reset

        sbar[0] = 1'b0; cyc(6); sbar[0] = 1'b1;    // debounced set ch0
        cyc(8);

        sbar[1] = 1'b0; cyc(2); sbar[1] = 1'b1;    // too-short pulse ch1
        cyc(8);

        sbar[2] = 1'b0; cyc(6); sbar[2] = 1'b1;    // ch2 -> 1
        cyc(6);
        sbar[2] = 1'b0; rbar[2] = 1'b0; cyc(6);    // both asserted
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;    // clear while held: set wins
        cyc(2);
        sbar[2] = 1'b1; rbar[2] = 1'b1; cyc(6);
        err_clr = 1'b1; cyc(1); err_clr = 1'b0;    // clear after release
        cyc(3);

        sbar[3] = 1'b0; cyc(6); sbar[3] = 1'b1;    // ch3 -> 1
        cyc(6);
        en = 1'b0; rbar[3] = 1'b0; cyc(8);         // frozen
        en = 1'b1; cyc(3); rbar[3] = 1'b1;
        cyc(6);

        sbar[0] = 1'b0; rbar[0] = 1'b1; cyc(2);    // reset mid-debounce
        sbar = 4'b1110;
        rst = 1'b1; cyc(1); rst = 1'b0;
        cyc(8); sbar[0] = 1'b1;
        cyc(6);

        for (int t = 0; t < 400; t++) begin        // randomized traffic
            if ($urandom_range(0, 3) == 0) begin
                int c;
                logic [1:0] v;
                c = $urandom_range(0, W-1);
                v = 2'($urandom_range(0, 3));
                sbar[c] = v[1];
                rbar[c] = v[0];
            end
            en      = ($urandom_range(0, 7) != 0);
            err_clr = ($urandom_range(0, 15) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        rst = 1'b0; en = 1'b1; err_clr = 1'b0; sbar = '1; rbar = '1;
        cyc(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
